// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one SRAM port between instruction fetch and data stage.
//            Define ROUND_ROBIN_EN for alternating grants; default is
//            fixed priority with the data stage winning.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_LEN = 32,
    parameter int WORD_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_LEN-1:0] if_addr,
    output logic [WORD_LEN-1:0] if_rdata,
    output logic                if_ready,
    input  logic                mem_rd_en,
    input  logic                mem_wr_en,
    input  logic [ADDR_LEN-1:0] mem_addr,
    input  logic [WORD_LEN-1:0] mem_wdata,
    output logic [WORD_LEN-1:0] mem_rdata,
    output logic                mem_ready,
    output logic                sram_rd_en,
    output logic                sram_wr_en,
    output logic [ADDR_LEN-1:0] sram_addr,
    output logic [WORD_LEN-1:0] sram_wdata,
    input  logic [WORD_LEN-1:0] sram_rdata,
    input  logic                sram_ready,
    output logic                grant_mem
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IF  = 2'd1,
        BUSY_MEM = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                sram_rd_en_q, sram_rd_en_d;
    logic                sram_wr_en_q, sram_wr_en_d;
    logic [ADDR_LEN-1:0] sram_addr_q, sram_addr_d;
    logic [WORD_LEN-1:0] sram_wdata_q, sram_wdata_d;
    logic [WORD_LEN-1:0] if_rdata_q, if_rdata_d;
    logic [WORD_LEN-1:0] mem_rdata_q, mem_rdata_d;
    logic                if_ready_q, if_ready_d;
    logic                mem_ready_q, mem_ready_d;

    logic w_if_pend;
    logic w_mem_pend;
    logic w_pick_mem;

    // A requester whose ready is pulsing this cycle is still holding its
    // request from the finished transaction, so it is masked for one cycle.
    assign w_if_pend  = if_req & ~if_ready_q;
    assign w_mem_pend = (mem_rd_en | mem_wr_en) & ~mem_ready_q;

`ifdef ROUND_ROBIN_EN
    logic last_mem_q, last_mem_d;
    assign w_pick_mem = w_mem_pend & (~w_if_pend | ~last_mem_q);
`else
    assign w_pick_mem = w_mem_pend;
`endif

    always_comb begin
        state_d      = state_q;
        sram_rd_en_d = sram_rd_en_q;
        sram_wr_en_d = sram_wr_en_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        if_rdata_d   = if_rdata_q;
        mem_rdata_d  = mem_rdata_q;
        if_ready_d   = 1'b0;
        mem_ready_d  = 1'b0;
`ifdef ROUND_ROBIN_EN
        last_mem_d   = last_mem_q;
`endif
        case (state_q)
            IDLE: begin
                if (w_pick_mem) begin
                    state_d      = BUSY_MEM;
                    sram_addr_d  = mem_addr;
                    sram_wdata_d = mem_wdata;
                    // Write takes precedence when both directions are set.
                    sram_wr_en_d = mem_wr_en;
                    sram_rd_en_d = ~mem_wr_en;
`ifdef ROUND_ROBIN_EN
                    last_mem_d   = 1'b1;
`endif
                end else if (w_if_pend) begin
                    state_d      = BUSY_IF;
                    sram_addr_d  = if_addr;
                    sram_rd_en_d = 1'b1;
                    sram_wr_en_d = 1'b0;
`ifdef ROUND_ROBIN_EN
                    last_mem_d   = 1'b0;
`endif
                end
            end
            BUSY_IF: begin
                if (sram_ready) begin
                    state_d      = IDLE;
                    sram_rd_en_d = 1'b0;
                    sram_wr_en_d = 1'b0;
                    if_rdata_d   = sram_rdata;
                    if_ready_d   = 1'b1;
                end
            end
            BUSY_MEM: begin
                if (sram_ready) begin
                    state_d      = IDLE;
                    sram_rd_en_d = 1'b0;
                    sram_wr_en_d = 1'b0;
                    mem_rdata_d  = sram_rdata;
                    mem_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d      = IDLE;
                sram_rd_en_d = 1'b0;
                sram_wr_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sram_rd_en_q <= 1'b0;
            sram_wr_en_q <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
            if_ready_q   <= 1'b0;
            mem_ready_q  <= 1'b0;
`ifdef ROUND_ROBIN_EN
            last_mem_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sram_rd_en_q <= sram_rd_en_d;
            sram_wr_en_q <= sram_wr_en_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            if_rdata_q   <= if_rdata_d;
            mem_rdata_q  <= mem_rdata_d;
            if_ready_q   <= if_ready_d;
            mem_ready_q  <= mem_ready_d;
`ifdef ROUND_ROBIN_EN
            last_mem_q   <= last_mem_d;
`endif
        end
    end

    assign sram_rd_en = sram_rd_en_q;
    assign sram_wr_en = sram_wr_en_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;
    assign if_rdata   = if_rdata_q;
    assign mem_rdata  = mem_rdata_q;
    assign if_ready   = if_ready_q;
    assign mem_ready  = mem_ready_q;
    assign grant_mem  = (state_q == BUSY_MEM);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter with a downstream
//            responder and a transaction-level arbitration model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        sram_rd_en;
    logic        sram_wr_en;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        sram_ready;
    logic        grant_mem;

    mem_port_arbiter #(.ADDR_LEN(32), .WORD_LEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_ready   (if_ready),
        .mem_rd_en  (mem_rd_en),
        .mem_wr_en  (mem_wr_en),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .sram_rd_en (sram_rd_en),
        .sram_wr_en (sram_wr_en),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .sram_ready (sram_ready),
        .grant_mem  (grant_mem)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_checks;
    int          n_fail;
    bit          model_last_mem;
    int          resp_delay;
    logic [31:0] resp_data;
    logic        force_ready;
    int          rd_cyc, wr_cyc, if_rdy_cnt, mem_rdy_cnt, both_cnt, en_cnt;

    // Downstream SRAM model: raises sram_ready in the resp_delay-th cycle of
    // an asserted enable; force_ready injects a stray pulse. Also tallies
    // enable cycles and ready pulses for the main sequence.
    initial begin
        sram_ready = 1'b0;
        sram_rdata = '0;
        rd_cyc = 0; wr_cyc = 0; if_rdy_cnt = 0; mem_rdy_cnt = 0;
        both_cnt = 0; en_cnt = 0;
        forever begin
            @(negedge clk);
            if (sram_rd_en) rd_cyc++;
            if (sram_wr_en) wr_cyc++;
            if (if_ready) if_rdy_cnt++;
            if (mem_ready) mem_rdy_cnt++;
            if (if_ready && mem_ready) both_cnt++;
            if (sram_rd_en || sram_wr_en) en_cnt++;
            else en_cnt = 0;
            sram_ready = force_ready || ((sram_rd_en || sram_wr_en) && en_cnt == resp_delay);
            sram_rdata = resp_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Arbitration rule: with both pending, round robin favours whoever was
    // not granted last; fixed priority always favours the data stage.
    function automatic bit exp_mem_wins(input bit if_p, input bit mem_p);
`ifdef ROUND_ROBIN_EN
        if (if_p && mem_p) return !model_last_mem;
        return mem_p;
`else
        return mem_p && (if_p || !if_p);
`endif
    endfunction

    // kind: 0 fetch, 1 data read, 2 data write, 3 data read+write
    task automatic run_single(input int kind, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input int dly, input bit chg,
                              input string tag);
        int cyc, rd0, wr0, ir0, mr0, bad, gm_bad;
        bit got, is_mem, is_wr;
        is_mem = (kind != 0);
        is_wr  = (kind >= 2);
        resp_delay = dly;
        resp_data  = rd;
        rd0 = rd_cyc; wr0 = wr_cyc; ir0 = if_rdy_cnt; mr0 = mem_rdy_cnt;
        if (!is_mem) begin
            if_req = 1'b1; if_addr = a;
        end else begin
            mem_rd_en = (kind == 1 || kind == 3);
            mem_wr_en = is_wr;
            mem_addr  = a;
            mem_wdata = wd;
        end
        model_last_mem = is_mem;
        cyc = 0; got = 1'b0; bad = 0; gm_bad = 0;
        while (!got && cyc < 64) begin
            @(posedge clk); #1;
            cyc++;
            if (chg) begin
                mem_addr = a + 32'd4; if_addr = a + 32'd4; mem_wdata = ~wd;
            end
            got = is_mem ? mem_ready : if_ready;
            if (!got) begin
                if (sram_addr !== a) bad++;
                if (is_wr && sram_wdata !== wd) bad++;
                if (grant_mem !== is_mem) gm_bad++;
            end
        end
        check($sformatf("%s latency", tag), 32'(cyc), 32'(dly + 1));
        check($sformatf("%s rdata", tag), is_mem ? mem_rdata : if_rdata, rd);
        check($sformatf("%s other_ready", tag), 32'(is_mem ? if_ready : mem_ready), 32'd0);
        if_req = 1'b0; mem_rd_en = 1'b0; mem_wr_en = 1'b0;
        @(posedge clk); #1;
        check($sformatf("%s addr_held", tag), 32'(bad), 32'd0);
        check($sformatf("%s sram_addr", tag), sram_addr, a);
        check($sformatf("%s grant_mem", tag), 32'(gm_bad), 32'd0);
        check($sformatf("%s rd_cycles", tag), 32'(rd_cyc - rd0), 32'(is_wr ? 0 : dly));
        check($sformatf("%s wr_cycles", tag), 32'(wr_cyc - wr0), 32'(is_wr ? dly : 0));
        check($sformatf("%s if_pulses", tag), 32'(if_rdy_cnt - ir0), 32'(is_mem ? 0 : 1));
        check($sformatf("%s mem_pulses", tag), 32'(mem_rdy_cnt - mr0), 32'(is_mem ? 1 : 0));
        check($sformatf("%s ready_drop", tag), 32'(if_ready | mem_ready), 32'd0);
    endtask

    task automatic run_pair(input logic [31:0] ai, input logic [31:0] am, input logic [31:0] ri,
                            input logic [31:0] rm, input int dly, input string tag);
        int cyc, t1;
        bit got, first_mem;
        first_mem  = exp_mem_wins(1'b1, 1'b1);
        resp_delay = dly;
        resp_data  = first_mem ? rm : ri;
        if_req = 1'b1; if_addr = ai;
        mem_rd_en = 1'b1; mem_wr_en = 1'b0; mem_addr = am;
        model_last_mem = first_mem;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 64) begin
            @(posedge clk); #1;
            cyc++;
            got = if_ready | mem_ready;
        end
        check($sformatf("%s first_is_mem", tag), 32'(mem_ready), 32'(first_mem));
        check($sformatf("%s first_not_if", tag), 32'(if_ready), 32'(!first_mem));
        check($sformatf("%s first_rdata", tag), first_mem ? mem_rdata : if_rdata, first_mem ? rm : ri);
        check($sformatf("%s first_latency", tag), 32'(cyc), 32'(dly + 1));
        t1 = cyc;
        if (first_mem) mem_rd_en = 1'b0;
        else if_req = 1'b0;
        resp_data = first_mem ? ri : rm;
        model_last_mem = !first_mem;
        got = 1'b0;
        while (!got && cyc < 128) begin
            @(posedge clk); #1;
            cyc++;
            got = if_ready | mem_ready;
        end
        check($sformatf("%s second_is_mem", tag), 32'(mem_ready), 32'(!first_mem));
        check($sformatf("%s second_rdata", tag), first_mem ? if_rdata : mem_rdata, first_mem ? ri : rm);
        check($sformatf("%s turnaround", tag), 32'(cyc - t1), 32'(dly + 1));
        if_req = 1'b0; mem_rd_en = 1'b0;
        @(posedge clk); #1;
        check($sformatf("%s no_dual_ready", tag), 32'(both_cnt), 32'd0);
    endtask

    initial begin
        int mr0, ir0, kind, dly;
        logic [31:0] a, d, r, r2;
        n_checks = 0; n_fail = 0; model_last_mem = 1'b0;
        rst = 1'b1; if_req = 1'b0; if_addr = '0;
        mem_rd_en = 1'b0; mem_wr_en = 1'b0; mem_addr = '0; mem_wdata = '0;
        force_ready = 1'b0; resp_delay = 1; resp_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset sram_rd_en", 32'(sram_rd_en), 32'd0);
        check("reset sram_wr_en", 32'(sram_wr_en), 32'd0);
        check("reset ready", 32'({if_ready, mem_ready}), 32'd0);
        check("reset grant_mem", 32'(grant_mem), 32'd0);
        check("reset sram_addr", sram_addr, 32'd0);
        check("reset rdata", if_rdata | mem_rdata | sram_wdata, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Stray sram_ready while idle must not produce anything.
        force_ready = 1'b1;
        @(posedge clk); #1;
        force_ready = 1'b0;
        @(posedge clk); #1;
        check("idle_ready pulses", 32'(if_rdy_cnt + mem_rdy_cnt), 32'd0);
        check("idle_ready enables", 32'({sram_rd_en, sram_wr_en}), 32'd0);

        run_single(0, 32'h40, 32'h0, 32'hE3A01005, 2, 1'b0, "fetch");
        @(posedge clk); #1;
        run_single(2, 32'h400, 32'hDEADBEEF, 32'h0, 5, 1'b0, "write");
        @(posedge clk); #1;
        run_pair(32'h100, 32'h200, 32'h11111111, 32'h22222222, 2, "pair1");

        // Reset during the second cycle of a data read, with sram_ready high.
        resp_delay = 20; mem_rd_en = 1'b1; mem_addr = 32'h80;
        mr0 = mem_rdy_cnt; ir0 = if_rdy_cnt;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort grant_mem_before", 32'(grant_mem), 32'd1);
        rst = 1'b1; force_ready = 1'b1; resp_data = 32'hBADBAD00;
        @(posedge clk); #1;
        rst = 1'b0; force_ready = 1'b0; mem_rd_en = 1'b0;
        model_last_mem = 1'b0;
        check("abort enables", 32'({sram_rd_en, sram_wr_en}), 32'd0);
        check("abort ready", 32'({if_ready, mem_ready}), 32'd0);
        check("abort grant_mem", 32'(grant_mem), 32'd0);
        check("abort addr_wdata", sram_addr | sram_wdata, 32'd0);
        check("abort rdata", if_rdata | mem_rdata, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("abort no_pulse", 32'((mem_rdy_cnt - mr0) + (if_rdy_cnt - ir0)), 32'd0);

        run_pair(32'h300, 32'h304, 32'hA5A5A5A5, 32'h5A5A5A5A, 1, "pair2");
        run_single(3, 32'h10, 32'h12345678, 32'h0, 3, 1'b0, "rdwr");
        @(posedge clk); #1;
        run_single(1, 32'h20, 32'h0, 32'hCAFEF00D, 4, 1'b1, "addr_change");
        @(posedge clk); #1;

        for (int i = 0; i < 24; i++) begin
            kind = int'($urandom_range(0, 4));
            dly  = int'($urandom_range(1, 6));
            a = $urandom; d = $urandom; r = $urandom; r2 = $urandom;
            if (kind == 4)
                run_pair(a, d, r, r2, dly, $sformatf("rnd%0d_pair", i));
            else
                run_single(kind, a, d, r, dly, (i % 3) == 0, $sformatf("rnd%0d_k%0d", i, kind));
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_LEN, default 32, sets the address width of all ports.
REQ-002 Parameter WORD_LEN, default 32, sets the data width of all ports.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 if_req  input  1  instruction-fetch read request; held until if_ready.
REQ-006 if_addr  input  ADDR_LEN  instruction-fetch address.
REQ-007 if_rdata  output  WORD_LEN  fetched word, valid while if_ready=1.
REQ-008 if_ready  output  1  one-cycle pulse marking fetch completion.
REQ-009 mem_rd_en  input  1  data-stage read request; held until mem_ready.
REQ-010 mem_wr_en  input  1  data-stage write request; held until mem_ready.
REQ-011 mem_addr  input  ADDR_LEN  data-stage address.
REQ-012 mem_wdata  input  WORD_LEN  data-stage write data.
REQ-013 mem_rdata  output  WORD_LEN  read word, valid while mem_ready=1.
REQ-014 mem_ready  output  1  one-cycle pulse marking data completion.
REQ-015 sram_rd_en  output  1  downstream read command.
REQ-016 sram_wr_en  output  1  downstream write command.
REQ-017 sram_addr  output  ADDR_LEN  downstream address.
REQ-018 sram_wdata  output  WORD_LEN  downstream write data.
REQ-019 sram_rdata  input  WORD_LEN  downstream read data, valid with sram_ready.
REQ-020 sram_ready  input  1  downstream one-cycle completion pulse.
REQ-021 grant_mem  output  1  1 while a data-stage transaction owns the downstream port.

Function
REQ-022 The block SHALL use a three-state FSM: IDLE, BUSY_IF, BUSY_MEM.
REQ-023 In IDLE with no request pending, the FSM SHALL stay in IDLE and hold all sram_* enables at 0.
REQ-024 In IDLE, a pending request SHALL be granted as follows.
- Decision in cycle N: the FSM moves to BUSY_IF or BUSY_MEM.
- Addr, wdata and direction are latched on the same edge.
- sram_rd_en/sram_wr_en are registered and SHALL assert in cycle N+1.
REQ-025 Commands SHALL come only from the latched registers; requester inputs changing mid-transaction SHALL have no effect.
REQ-026 A data-stage request with both mem_rd_en and mem_wr_en set SHALL be issued as a write.
REQ-027 The sram enable SHALL stay asserted until the cycle sram_ready=1 is sampled; on that edge it SHALL drop and the FSM SHALL return to IDLE.
REQ-028 On the sram_ready edge:
- sram_rdata SHALL be registered into if_rdata or mem_rdata, according to the owner.
- The matching ready output SHALL pulse for exactly one cycle, the cycle after sram_ready.
REQ-029 The FSM SHALL spend one IDLE turnaround cycle between consecutive transactions, so the minimum request-to-ready latency is 3 cycles with a 1-cycle downstream.
REQ-030 sram_ready while in IDLE SHALL be ignored.
REQ-031 if_ready and mem_ready SHALL never assert in the same cycle.
REQ-032 A requester that still holds its request in the cycle its ready pulses SHALL NOT be regranted in that cycle; the FSM sees it as a new request only in the following IDLE cycle.
REQ-033 grant_mem SHALL be 1 exactly while in BUSY_MEM.

Reset
REQ-034 When rst=1 on a clock edge, the block SHALL reset the following, including mid-transaction:
- FSM to IDLE.
- All enables, ready pulses and grant_mem to 0.
- if_rdata, mem_rdata, sram_addr and sram_wdata to 0.
- Last-grant pointer to IF.
REQ-035 An in-flight transaction aborted by reset SHALL NOT produce a ready pulse, even if sram_ready arrives in the reset cycle.

Configuration
REQ-036 Macro ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-037 With ROUND_ROBIN_EN undefined, fixed priority SHALL apply: a data-stage request always wins over if_req in IDLE.
REQ-038 With ROUND_ROBIN_EN defined, a one-bit last-grant pointer SHALL be updated on every grant.
- When both request, the requester not granted last SHALL win.
- When only one requests, it SHALL win regardless of the pointer.

Verification
REQ-039 The bench SHALL cover these scenarios:
- if_req=1, if_addr=0x40, sram_ready 1 cycle after sram_rd_en, sram_rdata=0xE3A01005 -> sram_addr=0x40, if_ready pulses once with if_rdata=0xE3A01005, latency 3 cycles.
- mem_wr_en=1, mem_addr=0x400, mem_wdata=0xDEADBEEF, sram_ready delayed 5 cycles -> sram_wr_en high for exactly 5 cycles, sram_wdata=0xDEADBEEF, then mem_ready pulses once.
- if_req and mem_rd_en asserted together, fixed priority -> data transaction completes first, IF granted after one IDLE cycle; with ROUND_ROBIN_EN after reset -> data granted first, next simultaneous pair grants IF.
- rst=1 two cycles into a BUSY_MEM read, with sram_ready pulsing in the reset cycle -> no mem_ready, all outputs 0 next cycle, FSM in IDLE.
- mem_rd_en and mem_wr_en both 1, mem_addr=0x10 -> sram_wr_en=1, sram_rd_en=0.
- mem_addr changed from 0x20 to 0x24 mid-transaction -> sram_addr stays 0x20 until completion.
